// File: rtl/m_display_pkg.sv
// Shared types and constants for the register-snooping 7-segment display.
// Holds the FSM state encoding, the default watched register and the blank pattern.
package m_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } conv_state_t;

  // One captured register write: the value and the mode it was written in.
  typedef struct packed {
    logic [31:0] data;
    logic        dec;
  } capture_t;

  localparam logic [4:0]  DEFAULT_WATCH_REG = 5'd17;  // s1
  localparam logic [6:0]  SEG_BLANK         = 7'b000_0000;
  localparam int unsigned CONV_STEPS        = 32;
  localparam logic [4:0]  LAST_STEP         = 5'(CONV_STEPS - 1);

endpackage

// File: rtl/m_7seg_decoder.sv
// Hex digit to 7-segment pattern, active-high segments ordered {g,f,e,d,c,b,a}.
module m_7seg_decoder (
  input  logic [3:0] digit,
  output logic [6:0] segment
);

  always_comb begin
    unique case (digit)
      4'h0: segment = 7'h3F;
      4'h1: segment = 7'h06;
      4'h2: segment = 7'h5B;
      4'h3: segment = 7'h4F;
      4'h4: segment = 7'h66;
      4'h5: segment = 7'h6D;
      4'h6: segment = 7'h7D;
      4'h7: segment = 7'h07;
      4'h8: segment = 7'h7F;
      4'h9: segment = 7'h6F;
      4'hA: segment = 7'h77;
      4'hB: segment = 7'h7C;
      4'hC: segment = 7'h39;
      4'hD: segment = 7'h5E;
      4'hE: segment = 7'h79;
      default: segment = 7'h71;
    endcase
  end

endmodule

// File: rtl/m_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/add-3 step per cycle for 32 cycles.
// done is high in the cycle whose closing edge performs the final step.
module m_bin2bcd_seq
  import m_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [31:0]             bin,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    overflow
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;

  logic [31:0]      bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;
  logic [4:0]       step_q;
  logic             running_q;
  logic             ovf_q;

  // NOTE: assign every always_comb output before any conditional update so no latch is inferred.
  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  // A bit leaving the top digit means the value no longer fits in NUM_DIGITS decimals;
  // the digits that remain are the value modulo 10^NUM_DIGITS.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q     <= '0;
      bcd_q     <= '0;
      step_q    <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (start) begin
      bin_q     <= bin;
      bcd_q     <= '0;
      step_q    <= '0;
      running_q <= 1'b1;
      ovf_q     <= 1'b0;
    end else if (running_q) begin
      bcd_q  <= {adj[BCD_W-2:0], bin_q[31]};
      bin_q  <= {bin_q[30:0], 1'b0};
      ovf_q  <= ovf_q | adj[BCD_W-1];
      step_q <= step_q + 5'd1;
      if (step_q == LAST_STEP) running_q <= 1'b0;
    end
  end

  assign done     = running_q && (step_q == LAST_STEP);
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/m_reg_display_scan.sv
// Snoops writes to one register-file entry and shows the value, in hex or unsigned
// decimal, on a multiplexed common 7-segment display.
module m_reg_display_scan
  import m_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 6,
  parameter logic [4:0]  WATCH_REG   = DEFAULT_WATCH_REG,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [4:0]            write_reg,
  input  logic [31:0]           write_data,
  input  logic                  dec_mode,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [6:0]            segment,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

  conv_state_t state_q, state_d;
  capture_t    cur_req, req, pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic        capture, req_valid;
  logic        conv_start, conv_done, conv_ovf, hex_load, commit;
  logic [BCD_W-1:0] conv_bcd;

  logic [NUM_DIGITS-1:0][3:0] disp_q;
  logic                       disp_dec_q;
  logic [CNT_W-1:0]           refresh_q;
  logic [IDX_W-1:0]           idx_q;
  logic [3:0]                 cur_digit;
  logic [6:0]                 dec_seg;
  logic                       blank;

  assign capture   = write_en && (write_reg == WATCH_REG);
  assign cur_req   = '{data: write_data, dec: dec_mode};
  // A write in the current cycle is newer than anything already waiting.
  assign req_valid = capture || pend_valid_q;
  assign req       = capture ? cur_req : pend_q;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    conv_start   = 1'b0;
    hex_load     = 1'b0;
    commit       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          pend_valid_d = 1'b0;
          if (req.dec) begin
            conv_start = 1'b1;
            state_d    = ST_CONVERT;
          end else begin
            hex_load = 1'b1;
          end
        end
      end
      ST_CONVERT: begin
        if (capture) begin
          pend_d       = cur_req;
          pend_valid_d = 1'b1;
        end
        if (conv_done) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        // Chain straight into the next conversion; a hex request waits one cycle in IDLE
        // so it does not collide with this commit.
        commit  = 1'b1;
        state_d = ST_IDLE;
        if (req_valid) begin
          if (req.dec) begin
            conv_start   = 1'b1;
            pend_valid_d = 1'b0;
            state_d      = ST_CONVERT;
          end else begin
            pend_d       = req;
            pend_valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  m_bin2bcd_seq #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (conv_start),
    .bin     (req.data),
    .done    (conv_done),
    .bcd     (conv_bcd),
    .overflow(conv_ovf)
  );

  // All digits change together, only from a hex load or a finished conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q     <= '0;
      disp_dec_q <= 1'b0;
      overflow   <= 1'b0;
    end else if (hex_load) begin
      disp_q     <= req.data[BCD_W-1:0];
      disp_dec_q <= 1'b0;
      overflow   <= 1'b0;
    end else if (commit) begin
      disp_q     <= conv_bcd;
      disp_dec_q <= 1'b1;
      overflow   <= conv_ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == LAST_CNT) begin
      refresh_q <= '0;
      idx_q     <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  // Leading-zero suppression: a digit is blank when it and every digit above it are zero.
  always_comb begin
    blank = 1'b0;
    if (disp_dec_q && (idx_q != '0)) begin
      blank = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if ((i >= int'(idx_q)) && (disp_q[i] != 4'd0)) blank = 1'b0;
      end
    end
  end

  assign cur_digit = disp_q[idx_q];

  m_7seg_decoder u_decoder (
    .digit  (cur_digit),
    .segment(dec_seg)
  );

  assign segment   = blank ? SEG_BLANK : dec_seg;
  assign digit_sel = ~(NUM_DIGITS'(1) << idx_q);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_m_reg_display_scan.sv
// Self-checking bench for m_reg_display_scan: randomized register writes checked against
// a value-level model of what each scanned digit should show.
module tb_m_reg_display_scan;

  localparam int unsigned ND    = 6;
  localparam int unsigned DIV   = 4;
  localparam logic [4:0]  WATCH = 5'd17;
  localparam logic [6:0]  SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write_en = 1'b0;
  logic [4:0]    write_reg = '0;
  logic [31:0]   write_data = '0;
  logic          dec_mode = 1'b0;
  logic [ND-1:0] digit_sel;
  logic [6:0]    segment;
  logic          busy;
  logic          overflow;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  // Model state: the value currently meant to be on the display and its mode.
  logic [31:0] shown_val = '0;
  logic        shown_dec = 1'b0;
  int unsigned edges = 0;  // rising edges since reset released

  m_reg_display_scan #(
    .NUM_DIGITS (ND),
    .WATCH_REG  (WATCH),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .write_en  (write_en),
    .write_reg (write_reg),
    .write_data(write_data),
    .dec_mode  (dec_mode),
    .digit_sel (digit_sel),
    .segment   (segment),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned cur_idx();
    return (edges / DIV) % ND;
  endfunction

  function automatic longint unsigned pow10(input int unsigned k);
    longint unsigned p = 1;
    for (int i = 0; i < int'(k); i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [ND-1:0] exp_sel();
    logic [ND-1:0] one = 1;
    return ~(one << cur_idx());
  endfunction

  function automatic logic [6:0] exp_seg();
    int unsigned     idx = cur_idx();
    longint unsigned v;
    int unsigned     d;
    if (!shown_dec) begin
      d = (shown_val >> (4 * idx)) & 32'hF;
      return SEG_TAB[d];
    end
    v = longint'(shown_val) % pow10(ND);
    if (idx != 0 && v < pow10(idx)) return 7'h00;
    d = int'((v / pow10(idx)) % 10);
    return SEG_TAB[d];
  endfunction

  function automatic logic exp_ovf();
    return shown_dec && (shown_val > 32'd999999);
  endfunction

  // Called at a falling edge; returns at the falling edge after the capture edge (cycle 1).
  task automatic do_write(input logic [4:0] r, input logic [31:0] d, input logic en,
                          input logic m);
    write_reg  = r;
    write_data = d;
    write_en   = en;
    dec_mode   = m;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (digit_sel !== 6'b111110 || segment !== SEG_TAB[0] || busy !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: sel=%b seg=%h busy=%b ovf=%b expected sel=111110 seg=%h busy=0 ovf=0",
               digit_sel, segment, busy, overflow, SEG_TAB[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      logic [5:0] want;
      if (c > 0) @(negedge clk);
      want = (c < 4) ? 6'b111110 : (c < 8) ? 6'b111101 : 6'b111011;
      tests_run++;
      if (digit_sel !== want) begin
        tests_failed++;
        $display("FAIL refresh_scan: cycle %0d sel=%b expected %b", c, digit_sel, want);
      end
    end
  endtask

  task automatic test_hex();
    logic [31:0] vals [4];
    vals[0] = 32'h00AB_CDEF;
    for (int i = 1; i < 4; i++) vals[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      do_write(WATCH, vals[i], 1'b1, 1'b0);
      shown_val = vals[i];
      shown_dec = 1'b0;
      for (int c = 0; c < 2 * ND * DIV; c++) begin
        if (c > 0) @(negedge clk);
        tests_run++;
        if (segment !== exp_seg() || digit_sel !== exp_sel() || busy !== 1'b0 || overflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL hex %h: c=%0d sel=%b seg=%h busy=%b ovf=%b expected sel=%b seg=%h busy=0 ovf=0",
                   vals[i], c, digit_sel, segment, busy, overflow, exp_sel(), exp_seg());
        end
      end
    end
  endtask

  // Dec write from idle: busy for cycles 1..33, old display held, new display at cycle 34.
  task automatic run_dec(input logic [31:0] v);
    logic exp_busy;
    do_write(WATCH, v, 1'b1, 1'b1);
    for (int c = 1; c <= 34 + ND * DIV; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 34) begin
        shown_val = v;
        shown_dec = 1'b1;
      end
      exp_busy = (c <= 33);
      tests_run++;
      if (busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL dec_busy %0d: c=%0d busy=%b expected %b", v, c, busy, exp_busy);
      end
      tests_run++;
      if (segment !== exp_seg() || digit_sel !== exp_sel() || overflow !== exp_ovf()) begin
        tests_failed++;
        $display("FAIL dec_display %0d: c=%0d sel=%b seg=%h ovf=%b expected sel=%b seg=%h ovf=%b",
                 v, c, digit_sel, segment, overflow, exp_sel(), exp_seg(), exp_ovf());
      end
    end
  endtask

  task automatic test_dec();
    run_dec(32'd123456);
    run_dec(32'd7);
    for (int i = 0; i < 3; i++) run_dec($urandom_range(999999, 0));
    run_dec($urandom);
  endtask

  task automatic test_overflow();
    run_dec(32'd1000000);
    run_dec(32'd999999);
    run_dec(32'hFFFF_FFFF);
    run_dec(32'd0);
  endtask

  task automatic test_filter();
    do_write(5'd16, $urandom, 1'b1, 1'b1);
    do_write(WATCH, $urandom, 1'b0, 1'b0);
    do_write(WATCH, $urandom, 1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || segment !== exp_seg() || digit_sel !== exp_sel() || overflow !== exp_ovf()) begin
        tests_failed++;
        $display("FAIL filter: c=%0d busy=%b seg=%h sel=%b ovf=%b expected busy=0 seg=%h sel=%b ovf=%b",
                 c, busy, segment, digit_sel, overflow, exp_seg(), exp_sel(), exp_ovf());
      end
    end
  endtask

  // First dec value, then up to two writes while busy (cycle 0 = none); the last one wins
  // and starts the moment the first commit finishes, so it shows at cycle 67.
  task automatic run_chain(input string tag, input logic [31:0] first, input logic [31:0] w1,
                           input int c1, input logic [31:0] w2, input int c2);
    logic exp_busy;
    do_write(WATCH, first, 1'b1, 1'b1);
    for (int c = 1; c <= 67 + ND * DIV; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 34) shown_val = first;
      if (c == 67) shown_val = w2;
      if (c >= 34) shown_dec = 1'b1;
      exp_busy = (c <= 66);
      tests_run++;
      if (busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL %s_busy: c=%0d busy=%b expected %b", tag, c, busy, exp_busy);
      end
      tests_run++;
      if (segment !== exp_seg() || digit_sel !== exp_sel() || overflow !== exp_ovf()) begin
        tests_failed++;
        $display("FAIL %s_display: c=%0d sel=%b seg=%h ovf=%b expected sel=%b seg=%h ovf=%b",
                 tag, c, digit_sel, segment, overflow, exp_sel(), exp_seg(), exp_ovf());
      end
      write_reg  = WATCH;
      dec_mode   = 1'b1;
      write_en   = (c1 > 0 && c == c1) || (c == c2);
      write_data = (c == c1) ? w1 : w2;
    end
    write_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_chain("b2b", 32'd5, 32'd7, 5, 32'd9, 10);
    run_chain("b2b_rand", $urandom_range(999999, 0), $urandom, 2, $urandom_range(9999999, 0), 31);
  endtask

  task automatic test_commit_capture();
    run_chain("commit_cap", $urandom_range(99999, 0), 32'd0, 0, $urandom_range(999999, 0), 33);
  endtask

  task automatic test_reset_mid();
    do_write(WATCH, 32'd424242, 1'b1, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_mid_busy: c=%0d busy=%b expected 1", c, busy);
      end
      write_reg  = WATCH;
      dec_mode   = 1'b1;
      write_data = 32'd31337;
      write_en   = (c == 3);
    end
    write_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (digit_sel !== 6'b111110 || segment !== SEG_TAB[0] || busy !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_immediate: sel=%b seg=%h busy=%b ovf=%b expected sel=111110 seg=%h busy=0 ovf=0",
               digit_sel, segment, busy, overflow, SEG_TAB[0]);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    shown_val = '0;
    shown_dec = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || segment !== exp_seg() || digit_sel !== exp_sel() || overflow !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_mid_after: c=%0d busy=%b seg=%h sel=%b ovf=%b expected busy=0 seg=%h sel=%b ovf=0",
                 c, busy, segment, digit_sel, overflow, exp_seg(), exp_sel());
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_hex();
    test_dec();
    test_overflow();
    test_filter();
    test_back_to_back();
    test_commit_capture();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/m_reg_display_scan.md
M_REG_DISPLAY_SCAN -- requirements
Module: M_REG_DISPLAY_SCAN

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, legal 1..8, meaning number of 7-segment digits driven.
REQ-002 SHALL have parameter WATCH_REG, default 5'd17 (s1), meaning register index snooped.
REQ-003 SHALL have parameter REFRESH_DIV, default 1000, legal >=2, meaning clk cycles each digit is lit.
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk  in  1  system clock, rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high.
REQ-006 SHALL have port: write_en  in  1  register-file write strobe.
REQ-007 SHALL have port: write_reg  in  5  destination register of current write.
REQ-008 SHALL have port: write_data  in  32  data being written.
REQ-009 SHALL have port: dec_mode  in  1  1 = unsigned decimal display, 0 = hex.
REQ-010 SHALL have port: digit_sel  out  NUM_DIGITS  active-low one-hot digit enable.
REQ-011 SHALL have port: segment  out  7  segment pattern for the selected digit, same polarity as M_7SEG_DECODER.
REQ-012 SHALL have port: busy  out  1  decimal conversion in progress.
REQ-013 SHALL have port: overflow  out  1  last decimal value exceeded 10^NUM_DIGITS-1.

Function
REQ-014 SHALL capture on a rising edge when write_en=1 and write_reg=WATCH_REG; dec_mode is sampled in the same cycle.
REQ-015 SHALL, in hex mode, load digit k with write_data[4k+3:4k] so it is visible from the next cycle, clear overflow, and leave busy low.
REQ-016 SHALL, in dec mode, run FSM IDLE -> CONVERT (32 shift/add-3 cycles) -> COMMIT (1 cycle) -> IDLE; busy is high in CONVERT and COMMIT; the new digits are visible 34 cycles after the capture edge.
REQ-017 SHALL set overflow at COMMIT if any carry left the top BCD digit; the display then shows the low NUM_DIGITS decimal digits.
REQ-018 SHALL update the display registers atomically, all digits in one cycle, never mid-conversion.
REQ-019 SHALL hold one pending slot for captures arriving while busy, last-wins; on return to IDLE a pending capture starts with no idle cycle.
REQ-020 SHALL process a capture arriving in the COMMIT cycle as pending, not dropped.
REQ-021 SHALL count refresh 0..REFRESH_DIV-1; on wrap, digit index advances 0..NUM_DIGITS-1 and wraps to 0.
REQ-022 SHALL drive digit_sel = ~(1<<index) and segment = decode(digit[index]).
REQ-023 SHALL, in dec mode, blank leading zero digits (all segments off); digit 0 is never blanked; hex mode never blanks.
REQ-024 SHALL ignore writes with write_en=0 or any other write_reg.

Reset
REQ-025 SHALL, on reset assertion, asynchronously clear to: digits all 0, index 0, refresh count 0, FSM IDLE, pending empty, busy 0, overflow 0, digit_sel = ~1, segment = decode(0).
REQ-026 SHALL abort any conversion in progress on reset and discard the pending slot.

Structure
REQ-027 SHALL place the FSM state enum, the default WATCH_REG and the blank-segment constant in package M_DISPLAY_PKG.
REQ-028 SHALL implement the converter as sub-module M_BIN2BCD_SEQ (start/done handshake, BCD and overflow outputs), and reuse one M_7SEG_DECODER instance after the digit mux.

Verification
REQ-029 SHALL verify hex mode: write reg 17 with 0x00ABCDEF, REFRESH_DIV=4 -> digits F,E,D,C,B,A next cycle; digit_sel 6'b111110 for 4 cycles, then 6'b111101.
REQ-030 SHALL verify dec mode: write 123456 -> busy high 33 cycles; display 1,2,3,4,5,6 at cycle 34; overflow 0.
REQ-031 SHALL verify overflow: dec mode, write 1000000 -> overflow 1; only digit 0 lit, showing "0"; digits 1-5 blanked.
REQ-032 SHALL verify filtering and buffering: a write to reg 16, and a write with write_en=0 -> no change; dec mode, write 5, then 7 and 9 while busy -> display 5, then 9; 7 is never shown.
REQ-033 SHALL verify reset mid-conversion: reset asserted in CONVERT cycle 10 with a pending write -> outputs at REQ-025 values immediately; no commit follows.
